// File: rtl/seq_driver.sv
// Drives a 5-state external sequencer through a full reset/advance walk.
// At each step it compares the sequencer's state code and terminal flag with the expected values.
module seq_driver #(
    parameter int GAP   = 0,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             abort,
    input  logic [4:0]       seq_out,
    input  logic             seq_ready,
    output logic             seq_rst,
    output logic             seq_start,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] run_count
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    state_t     state;
    logic [2:0] exp_code;
    logic [3:0] gap_cnt;
    logic       in_run;
    logic       code_ok;
    logic       ready_ok;

    // The upper seq_out bits take part in the match, so codes above 7 also fail as a code mismatch.
    assign in_run   = (state == ST_CLEAR) || (state == ST_COMPARE) || (state == ST_HOLD) ||
                      (state == ST_ADVANCE) || (state == ST_DONE) || (state == ST_FAIL);
    assign code_ok  = (seq_out == {2'b00, exp_code});
    assign ready_ok = (seq_ready == (exp_code == 3'd4));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            exp_code  <= 3'd0;
            gap_cnt   <= 4'd0;
            seq_rst   <= 1'b0;
            seq_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
            run_count <= '0;
        end else begin
            seq_rst   <= 1'b0;
            seq_start <= 1'b0;
            done      <= 1'b0;
            // Abort wins over whatever the current state would have done, including a pending start.
            if (in_run && abort) begin
                state    <= ST_FAIL;
                busy     <= 1'b1;
                err      <= 1'b1;
                err_code <= 2'b11;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (go) begin
                            state    <= ST_CLEAR;
                            seq_rst  <= 1'b1;
                            busy     <= 1'b1;
                            err      <= 1'b0;
                            err_code <= 2'b00;
                        end
                    end
                    ST_CLEAR: begin
                        exp_code <= 3'd0;
                        state    <= ST_COMPARE;
                    end
                    ST_COMPARE: begin
                        if (!code_ok) begin
                            state    <= ST_FAIL;
                            err      <= 1'b1;
                            err_code <= 2'b01;
                        end else if (!ready_ok) begin
                            state    <= ST_FAIL;
                            err      <= 1'b1;
                            err_code <= 2'b10;
                        end else if (exp_code == 3'd4) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            if (run_count != {CNT_W{1'b1}}) begin
                                run_count <= run_count + CNT_W'(1);
                            end
                        end else if (GAP > 0) begin
                            state   <= ST_HOLD;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state     <= ST_ADVANCE;
                            seq_start <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (gap_cnt == 4'd0) begin
                            state     <= ST_ADVANCE;
                            seq_start <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                    ST_ADVANCE: begin
                        exp_code <= exp_code + 3'd1;
                        state    <= ST_COMPARE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    ST_FAIL: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_driver.sv
// Scoreboard bench for seq_driver: a behavioural sequencer with selectable faults, run-level
// outcome prediction from the step timing, and a monitor that checks every done/err event.
module tb_seq_driver;

    localparam int GAP   = 3;
    localparam int CNT_W = 8;
    localparam int STEP  = GAP + 2;
    localparam int LAT   = 10 + 4 * GAP;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             go = 1'b0;
    logic             abort = 1'b0;
    logic [4:0]       seq_out;
    logic             seq_ready;
    logic             seq_rst;
    logic             seq_start;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [CNT_W-1:0] run_count;

    seq_driver #(.GAP(GAP), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .seq_out(seq_out), .seq_ready(seq_ready),
        .seq_rst(seq_rst), .seq_start(seq_start), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .run_count(run_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Fault modes: 0 good, 1 stuck at code 2, 2 ready early at code 3, 3 stray bit 3 at code 1, 4 good + abort.
    int         fault_mode = 0;
    logic [2:0] seq_code = 3'd0;

    always @(posedge clk) begin
        if (seq_rst) seq_code <= 3'd0;
        else if (seq_start && !(fault_mode == 1 && seq_code == 3'd2) && seq_code != 3'd7)
            seq_code <= seq_code + 3'd1;
    end

    assign seq_out   = (fault_mode == 3 && seq_code == 3'd1) ? {2'b01, seq_code} : {2'b00, seq_code};
    assign seq_ready = (seq_code == 3'd4) || (fault_mode == 2 && seq_code == 3'd3);

    typedef struct {
        bit         is_done;
        logic [1:0] code;
        int         at_cyc;
        logic [7:0] count;
        int         starts;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_count = 8'd0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, actual, required, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse or err rise.
    bit   prev_err = 1'b0;
    bit   prev_start = 1'b0;
    bit   busy_pending = 1'b0;
    int   start_count = 0;
    exp_t got;

    always @(negedge clk) begin
        if (!reset) begin
            prev_err = 1'b0;
            prev_start = 1'b0;
            busy_pending = 1'b0;
            start_count = 0;
        end else begin
            if (busy_pending) begin
                check_output("busy_low_after_end", busy, 0);
                busy_pending = 1'b0;
            end
            if (seq_start) begin
                check_output("start_with_rst", seq_rst, 0);
                check_output("start_back_to_back", prev_start, 0);
            end
            if (seq_rst) start_count = 0;
            if (seq_start) start_count++;
            if (done || (err && !prev_err)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_event done=%0b err=%0b at cycle %0d", done, err, cyc);
                end else begin
                    got = sb.pop_front();
                    check_output("event_kind", {done, err}, got.is_done ? 2'b10 : 2'b01);
                    check_output("event_cycle", cyc, got.at_cyc);
                    check_output("err_code", err_code, got.code);
                    check_output("run_count", run_count, got.count);
                    check_output("start_pulses", start_count, got.starts);
                    check_output("busy_during_end", busy, 1);
                end
                busy_pending = 1'b1;
            end
            prev_err = err;
            prev_start = seq_start;
        end
    end

    // One run: pulse go, predict the outcome, optionally inject abort or a stray go, wait it out.
    task automatic apply_stimulus(input int mode, input int abort_at, input bit noise, input int noise_at);
        exp_t e;
        int   n;
        int   end_off;
        fault_mode = (mode == 4) ? 0 : mode;
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        n = cyc;
        check_output("err_clear_on_go", {err, err_code}, 3'b000);
        check_output("clear_rst_busy", {seq_rst, busy}, 2'b11);
        e.count = model_count;
        e.starts = 0;
        case (mode)
            0: begin
                end_off = LAT;
                e.is_done = 1'b1;
                e.code = 2'b00;
                e.starts = 4;
                if (model_count != 8'hFF) model_count = model_count + 8'd1;
                e.count = model_count;
            end
            1: begin end_off = 2 + 3 * STEP; e.is_done = 1'b0; e.code = 2'b01; e.starts = 3; end
            2: begin end_off = 2 + 3 * STEP; e.is_done = 1'b0; e.code = 2'b10; e.starts = 3; end
            3: begin end_off = 2 + STEP;     e.is_done = 1'b0; e.code = 2'b01; e.starts = 1; end
            default: begin
                end_off = abort_at + 1;
                e.is_done = 1'b0;
                e.code = 2'b11;
                for (int k = 0; k < 4; k++) if ((k + 1) * STEP <= abort_at) e.starts++;
            end
        endcase
        e.at_cyc = n + end_off;
        sb.push_back(e);
        for (int c = 0; c <= end_off + 2; c++) begin
            abort = (mode == 4 && c == abort_at);
            go = (noise && mode == 0 && c == noise_at);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        go = 1'b0;
    endtask

    task automatic reset_during_hold();
        fault_mode = 0;
        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3;
        reset = 1'b0;
        #1;
        check_output("reset_mid_hold_outputs",
                     {seq_rst, seq_start, busy, done, err, err_code, run_count}, 0);
        model_count = 8'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_output("idle_after_release", {busy, seq_rst}, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_output("reset_outputs", {seq_rst, seq_start, busy, done, err, err_code, run_count}, 0);
        reset = 1'b1;

        apply_stimulus(0, 0, 1'b0, 0);
        apply_stimulus(1, 0, 1'b0, 0);
        apply_stimulus(2, 0, 1'b0, 0);
        apply_stimulus(0, 0, 1'b1, 7);
        apply_stimulus(3, 0, 1'b0, 0);
        apply_stimulus(4, 1 + 2 * STEP, 1'b0, 0);
        apply_stimulus(4, 0, 1'b0, 0);
        apply_stimulus(4, LAT - 1, 1'b0, 0);
        apply_stimulus(4, STEP, 1'b0, 0);
        reset_during_hold();
        apply_stimulus(0, 0, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            apply_stimulus($urandom_range(0, 4), $urandom_range(0, LAT - 1),
                           1'($urandom_range(0, 1)), $urandom_range(1, LAT - 1));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        for (int i = 0; i < 260; i++) apply_stimulus(0, 0, 1'b0, 0);

        repeat (4) @(posedge clk);
        check_output("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_driver.md
SEQ_DRIVER -- requirements
Module: seq_driver

Interface
REQ-001 Parameter GAP, default 0: idle cycles inserted between a passing compare and the next start pulse (0..15).
REQ-002 Parameter CNT_W, default 8: width of run_count.
REQ-003 clk  input  1  single clock; all flops rise-edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 go  input  1  host request; sampled only in IDLE.
REQ-006 abort  input  1  host cancel; effective in any non-IDLE state.
REQ-007 seq_out  input  5  sequencer state code, expected 0..4.
REQ-008 seq_ready  input  1  sequencer terminal-state flag.
REQ-009 seq_rst  output  1  active-high synchronous reset to sequencer.
REQ-010 seq_start  output  1  single-cycle advance pulse to sequencer.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on successful run.
REQ-013 err  output  1  sticky failure flag.
REQ-014 err_code  output  2  01 code mismatch, 10 ready mismatch, 11 aborted, 00 none.
REQ-015 run_count  output  CNT_W  successful runs, saturating.

Function
REQ-016 States IDLE, CLEAR, COMPARE, HOLD, ADVANCE, DONE, FAIL; 3-bit internal encoding; an unused code SHALL return to IDLE next cycle.
REQ-017 IDLE: go=1 -> CLEAR; err and err_code cleared on that transition; go=1 outside IDLE is ignored.
REQ-018 CLEAR: seq_rst=1 for exactly one cycle; expected register exp<=0; -> COMPARE.
REQ-019 COMPARE: seq_out!=exp -> FAIL, code 01 (code check takes priority).
REQ-020 COMPARE: seq_out==exp but seq_ready!=(exp==4) -> FAIL, code 10.
REQ-021 COMPARE pass with exp==4 -> DONE; pass with exp<4 -> HOLD if GAP>0, else ADVANCE.
REQ-022 HOLD: 4-bit gap counter loaded with GAP-1 on entry, decrements per cycle; at 0 -> ADVANCE.
REQ-023 ADVANCE: seq_start=1 for exactly one cycle; exp<=exp+1; -> COMPARE.
REQ-024 seq_start and seq_rst SHALL never be high in the same cycle, and seq_start SHALL never be high two consecutive cycles.
REQ-025 DONE: done=1 one cycle; run_count+=1 unless at all-ones; -> IDLE.
REQ-026 FAIL: err<=1 with err_code latched; -> IDLE; err/err_code hold until next accepted go or reset.
REQ-027 abort=1 in any non-IDLE state -> FAIL with code 11, overriding compare results that cycle; no seq_start that cycle.
REQ-028 Latency, GAP=0: go sampled at edge N -> done high in cycle N+10 (CLEAR, 5 COMPARE, 4 ADVANCE, DONE); general 10+4*GAP.
REQ-029 seq_out bits [4:3] nonzero SHALL fail as code 01.
REQ-030 exp is 3 bits; it never exceeds 4.

Reset
REQ-031 reset low asynchronously forces IDLE, exp=0, gap counter=0, seq_rst=0, seq_start=0, busy=0, done=0, err=0, err_code=00, run_count=0.
REQ-032 Reset asserted mid-run aborts without done/err; first cycle after release is IDLE.

Verification
REQ-033 Compliant sequencer model, GAP=0, go pulse -> seq_rst 1 cycle, 4 seq_start pulses 2 cycles apart, done at N+10, run_count 0->1, err=0.
REQ-034 Model stuck at code 2 (ignores 3rd start) -> FAIL, err=1, err_code=01, no done, run_count unchanged.
REQ-035 Model asserts ready at code 3 -> err_code=10; then go again with good model -> err clears on go, done, err=0.
REQ-036 abort asserted in third COMPARE -> err_code=11, busy low next cycle, no seq_start that cycle.
REQ-037 GAP=3 -> start pulses 5 cycles apart, done at N+22; 256 good runs with CNT_W=8 -> run_count stays 255.
REQ-038 reset pulled low during HOLD -> all outputs zero immediately; go after release -> normal run.
